// File: rtl/arp_ctrl.sv
// arp_ctrl: ARP sequencing controller; answers requests, resolves host IPs with timeout/retry,
// and keeps a single-entry IP-to-MAC cache fed by every received ARP frame.
module arp_ctrl #(
    parameter int TIMEOUT_CYCLES = 125_000_000,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] rx_source_mac,
    input  logic [31:0] rx_source_ip,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] tx_dest_mac,
    output logic [31:0] tx_dest_ip,
    input  logic        arp_tx_done,
    output logic        cache_valid,
    output logic [31:0] cache_ip,
    output logic [47:0] cache_mac,
    output logic        resolve_done,
    output logic        resolve_fail,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, TX_REPLY, WAIT_REPLY_TX, TX_REQ, WAIT_REQ_TX, WAIT_RESP} state_t;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       R_MAX  = 8'(MAX_RETRY);
    state_t state, next_state;
    logic reply_pend, resume;
    logic [47:0] reply_mac;
    logic [31:0] reply_ip, target_ip;
    logic [7:0] retry_cnt;
    logic [CNT_W-1:0] timer;
    logic rx_req, match, hit, timeout;
    logic load_reply, load_req, accept, hit_done, match_done, fail, retry_inc, timer_clr, timer_inc, set_resume;
    assign rx_req    = arp_rx_done && !arp_rx_type;
    assign match     = arp_rx_done && rx_source_ip == target_ip;
    assign hit       = cache_valid && cache_ip == resolve_ip;
    assign timeout   = timer == T_LAST;
    assign arp_tx_en = state == TX_REPLY || state == TX_REQ;
    assign busy      = state != IDLE;
    always_comb begin
        next_state = state;
        load_reply = 1'b0;
        load_req   = 1'b0;
        accept     = 1'b0;
        hit_done   = 1'b0;
        match_done = 1'b0;
        fail       = 1'b0;
        retry_inc  = 1'b0;
        timer_clr  = 1'b0;
        timer_inc  = 1'b0;
        set_resume = 1'b0;
        case (state)
            IDLE: begin
                // a request arriving now wins over a simultaneous resolve_req, which is dropped
                if (reply_pend) begin
                    load_reply = 1'b1;
                    next_state = TX_REPLY;
                end else if (resolve_req && !rx_req) begin
                    hit_done   = hit;
                    accept     = !hit;
                    load_req   = !hit;
                    next_state = hit ? IDLE : TX_REQ;
                end
            end
            TX_REPLY:      next_state = WAIT_REPLY_TX;
            WAIT_REPLY_TX: next_state = !arp_tx_done ? state : resume ? WAIT_RESP : IDLE;
            TX_REQ:        next_state = WAIT_REQ_TX;
            WAIT_REQ_TX: begin
                timer_clr  = arp_tx_done;
                next_state = arp_tx_done ? WAIT_RESP : state;
            end
            WAIT_RESP: begin
                // an incoming non-matching request freezes the timer until its reply is sent
                if (match) begin
                    match_done = 1'b1;
                    next_state = IDLE;
                end else if (reply_pend) begin
                    set_resume = 1'b1;
                    load_reply = 1'b1;
                    next_state = TX_REPLY;
                end else if (!rx_req) begin
                    if (timeout) begin
                        retry_inc  = retry_cnt < R_MAX;
                        load_req   = retry_cnt < R_MAX;
                        fail       = retry_cnt >= R_MAX;
                        next_state = retry_cnt < R_MAX ? TX_REQ : IDLE;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            reply_pend   <= 1'b0;
            resume       <= 1'b0;
            reply_mac    <= '0;
            reply_ip     <= '0;
            target_ip    <= '0;
            retry_cnt    <= '0;
            timer        <= '0;
            arp_tx_type  <= 1'b0;
            tx_dest_mac  <= '0;
            tx_dest_ip   <= '0;
            cache_valid  <= 1'b0;
            cache_ip     <= '0;
            cache_mac    <= '0;
            resolve_done <= 1'b0;
            resolve_fail <= 1'b0;
        end else begin
            state        <= next_state;
            reply_pend   <= rx_req || (reply_pend && !load_reply);
            resume       <= set_resume || (resume && !(state == WAIT_REPLY_TX && arp_tx_done));
            timer        <= timer_clr ? '0 : timer_inc ? timer + 1'b1 : timer;
            retry_cnt    <= (accept || match_done) ? '0 : retry_inc ? retry_cnt + 1'b1 : retry_cnt;
            resolve_done <= hit_done || match_done;
            resolve_fail <= fail;
            if (accept)
                target_ip <= resolve_ip;
            if (rx_req) begin
                reply_mac <= rx_source_mac;
                reply_ip  <= rx_source_ip;
            end
            if (arp_rx_done) begin
                cache_valid <= 1'b1;
                cache_ip    <= rx_source_ip;
                cache_mac   <= rx_source_mac;
            end
            if (load_reply) begin
                arp_tx_type <= 1'b1;
                tx_dest_mac <= reply_mac;
                tx_dest_ip  <= reply_ip;
            end else if (load_req) begin
                arp_tx_type <= 1'b0;
                tx_dest_mac <= '1;
                tx_dest_ip  <= accept ? resolve_ip : target_ip;
            end
        end
    end
endmodule

// File: tb/tb_arp_ctrl.sv
// tb_arp_ctrl: scoreboard bench for arp_ctrl; stimulus pushes expected tx/done/fail events
// with their exact cycle, a monitor pops and compares whenever the DUT pulses one.
module tb_arp_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic arp_rx_done = 1'b0, arp_rx_type = 1'b0, resolve_req = 1'b0, arp_tx_done = 1'b0;
    logic [47:0] rx_source_mac = '0;
    logic [31:0] rx_source_ip = '0, resolve_ip = '0;
    logic arp_tx_en, arp_tx_type, cache_valid, resolve_done, resolve_fail, busy;
    logic [47:0] tx_dest_mac, cache_mac;
    logic [31:0] tx_dest_ip, cache_ip;
    logic tx_mute = 1'b0;
    int cyc = 0, checks = 0, failures = 0;
    typedef struct {int kind; logic typ; logic [47:0] mac; logic [31:0] ip; int at;} exp_t;
    exp_t q[$];
    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

    arp_ctrl #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .rx_source_mac(rx_source_mac), .rx_source_ip(rx_source_ip), .resolve_req(resolve_req),
        .resolve_ip(resolve_ip), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .tx_dest_mac(tx_dest_mac), .tx_dest_ip(tx_dest_ip), .arp_tx_done(arp_tx_done),
        .cache_valid(cache_valid), .cache_ip(cache_ip), .cache_mac(cache_mac),
        .resolve_done(resolve_done), .resolve_fail(resolve_fail), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic typ, input logic [47:0] mac, input logic [31:0] ip, input int at);
        exp_t e;
        e.kind = kind; e.typ = typ; e.mac = mac; e.ip = ip; e.at = at;
        q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d required=none", kind, cyc);
        end else begin
            e = q.pop_front();
            if (kind == 0 && e.kind == 0)
                chk("tx_frame", 160'({32'(kind), arp_tx_type, tx_dest_mac, tx_dest_ip, 32'(cyc)}),
                    160'({32'(e.kind), e.typ, e.mac, e.ip, 32'(e.at)}));
            else
                chk(kind == 0 ? "tx_frame" : kind == 1 ? "resolve_done" : "resolve_fail",
                    160'({32'(kind), 32'(cyc)}), 160'({32'(e.kind), 32'(e.at)}));
        end
    endtask

    // monitor: kind 0 = frame start, 1 = resolve_done, 2 = resolve_fail
    always @(negedge clk) if (rst_n) begin
        if (arp_tx_en) pop_cmp(0);
        if (resolve_done) pop_cmp(1);
        if (resolve_fail) pop_cmp(2);
    end

    // transmitter model: frame done pulse three cycles after the start pulse
    initial forever begin
        @(negedge clk);
        if (arp_tx_en && !tx_mute) begin
            repeat (3) @(posedge clk);
            #1 arp_tx_done = 1'b1;
            @(posedge clk);
            #1 arp_tx_done = 1'b0;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            step();
            n++;
        end
        chk("idle_within_bound", 160'(busy), 160'(0));
    endtask

    task automatic rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1; arp_rx_type = typ; rx_source_mac = mac; rx_source_ip = ip;
        step();
        arp_rx_done = 1'b0;
    endtask

    task automatic rsv(input logic [31:0] ip);
        resolve_req = 1'b1; resolve_ip = ip;
        step();
        resolve_req = 1'b0;
    endtask

    initial begin
        int m;
        step(3);
        chk("reset_tx_outputs", 160'({arp_tx_en, arp_tx_type, tx_dest_mac, tx_dest_ip, busy}), 160'(0));
        chk("reset_cache_outputs", 160'({cache_valid, cache_ip, cache_mac, resolve_done, resolve_fail}), 160'(0));
        rst_n = 1'b1;
        step(2);
        // incoming request: reply at N+2, cache at N+1, busy drops after done (N+5) at N+6
        m = cyc;
        expect_ev(0, 1'b1, 48'h0011_2233_4455, 32'hc0a8_0102, m + 2);
        rx(1'b0, 48'h0011_2233_4455, 32'hc0a8_0102);
        chk("cache_after_req", 160'({cache_valid, cache_ip, cache_mac}), 160'({1'b1, 32'hc0a8_0102, 48'h0011_2233_4455}));
        wait_cyc(m + 5);
        chk("busy_before_tx_done", 160'(busy), 160'(1));
        step();
        chk("busy_after_tx_done", 160'(busy), 160'(0));
        // cache hit: done next cycle, no frame
        step();
        m = cyc;
        expect_ev(1, 1'b0, '0, '0, m + 1);
        rsv(32'hc0a8_0102);
        chk("busy_on_hit", 160'(busy), 160'(0));
        step(5);
        // miss: request at M+1, done at M+4, WAIT_RESP cycle 0 is M+5, reply at cycle 40 = M+45
        m = cyc;
        expect_ev(0, 1'b0, BCAST, 32'hc0a8_0105, m + 1);
        expect_ev(1, 1'b0, '0, '0, m + 46);
        rsv(32'hc0a8_0105);
        wait_cyc(m + 45);
        rx(1'b1, 48'haabb_ccdd_ee01, 32'hc0a8_0105);
        chk("cache_after_resolve", 160'({cache_ip, cache_mac}), 160'({32'hc0a8_0105, 48'haabb_ccdd_ee01}));
        chk("idle_after_resolve", 160'(busy), 160'(0));
        // timeout: timer 0..99 after each done, so frames every 104 cycles, fail 104 after the last
        step();
        m = cyc;
        for (int k = 0; k < 4; k++) expect_ev(0, 1'b0, BCAST, 32'hc0a8_0106, m + 1 + 104 * k);
        expect_ev(2, 1'b0, '0, '0, m + 417);
        rsv(32'hc0a8_0106);
        wait_idle(600);
        chk("cache_kept_on_fail", 160'({cache_ip, cache_mac}), 160'({32'hc0a8_0105, 48'haabb_ccdd_ee01}));
        // interleave: request at timer 50 -> reply frame at M+57, done M+60, timer resumes at 50 from M+61
        step();
        m = cyc;
        expect_ev(0, 1'b0, BCAST, 32'hc0a8_0109, m + 1);
        expect_ev(0, 1'b1, 48'h02a0_b0c0_d0e0, 32'hc0a8_0777, m + 57);
        for (int k = 0; k < 3; k++) expect_ev(0, 1'b0, BCAST, 32'hc0a8_0109, m + 111 + 104 * k);
        expect_ev(2, 1'b0, '0, '0, m + 423);
        rsv(32'hc0a8_0109);
        wait_cyc(m + 55);
        rx(1'b0, 48'h02a0_b0c0_d0e0, 32'hc0a8_0777);
        wait_idle(600);
        chk("cache_from_interleaved_req", 160'(cache_ip), 160'(32'hc0a8_0777));
        // simultaneous request and resolve_req in IDLE: only the reply frame goes out
        step();
        m = cyc;
        expect_ev(0, 1'b1, 48'h6666_7777_8888, 32'hc0a8_0203, m + 2);
        arp_rx_done = 1'b1; arp_rx_type = 1'b0; rx_source_mac = 48'h6666_7777_8888; rx_source_ip = 32'hc0a8_0203;
        resolve_req = 1'b1; resolve_ip = 32'hc0a8_0300;
        step();
        arp_rx_done = 1'b0; resolve_req = 1'b0;
        step(10);
        wait_idle(50);
        // async reset while waiting for tx done, then a fresh resolve is accepted
        tx_mute = 1'b1;
        m = cyc;
        expect_ev(0, 1'b0, BCAST, 32'hc0a8_000a, m + 1);
        rsv(32'hc0a8_000a);
        wait_cyc(m + 3);
        chk("busy_in_wait_req_tx", 160'({busy, tx_dest_mac}), 160'({1'b1, BCAST}));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_tx_outputs", 160'({arp_tx_en, arp_tx_type, tx_dest_mac, tx_dest_ip, busy}), 160'(0));
        chk("async_reset_cache_outputs", 160'({cache_valid, cache_ip, cache_mac, resolve_done, resolve_fail}), 160'(0));
        #2 rst_n = 1'b1;
        step(2);
        tx_mute = 1'b0;
        m = cyc;
        expect_ev(0, 1'b0, BCAST, 32'hc0a8_0102, m + 1);
        expect_ev(1, 1'b0, '0, '0, m + 11);
        rsv(32'hc0a8_0102);
        wait_cyc(m + 10);
        rx(1'b1, 48'h0011_2233_4455, 32'hc0a8_0102);
        step(3);
        chk("scoreboard_drained", 160'(q.size()), 160'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arp_ctrl.md
Name: arp_ctrl

Overview:
Sequencing controller for the Ethernet MMIO peripheral's ARP path. It sits between the ARP receiver, the ARP transmitter and the host-facing MMIO registers.
- Answers incoming ARP requests with replies.
- Resolves host-requested IPs by sending ARP requests, with timeout and retry.
- Maintains a single-entry IP-to-MAC cache, which it updates from every valid received ARP frame.

Parameters:
TIMEOUT_CYCLES, 125_000_000, cycles to wait for an ARP reply before retrying (1 s at 125 MHz GMII clock)
MAX_RETRY, 3, number of request retransmissions after the first before failure
CNT_W, 27, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  GMII receive/system clock
rst_n  in  1  reset, asynchronous, active-low
arp_rx_done  in  1  one-cycle pulse from receiver: valid ARP frame addressed to us
arp_rx_type  in  1  0 = request received, 1 = reply received; valid with arp_rx_done
rx_source_mac  in  48  sender MAC; valid with arp_rx_done
rx_source_ip  in  32  sender IP; valid with arp_rx_done
resolve_req  in  1  one-cycle pulse from MMIO: resolve resolve_ip
resolve_ip  in  32  target IP; sampled on accepted resolve_req
arp_tx_en  out  1  one-cycle pulse: start transmitter
arp_tx_type  out  1  0 = send request, 1 = send reply
tx_dest_mac  out  48  destination MAC for transmitter (ff_ff_ff_ff_ff_ff for request)
tx_dest_ip  out  32  target IP for transmitter
arp_tx_done  in  1  one-cycle pulse: transmitter finished frame
cache_valid  out  1  cache entry holds a valid pair
cache_ip  out  32  cached IP
cache_mac  out  48  cached MAC
resolve_done  out  1  one-cycle pulse: resolve_ip found, cache holds it
resolve_fail  out  1  one-cycle pulse: retries exhausted
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0, tx_dest_mac 0, cache invalid. Internal state: state IDLE, retry_cnt 0, timer 0, reply_pend 0.
- States: IDLE, TX_REPLY, WAIT_REPLY_TX, TX_REQ, WAIT_REQ_TX, WAIT_RESP.
- Cache update, any state: on arp_rx_done (request or reply), write cache_ip and cache_mac from the rx ports and set cache_valid. Outputs update the cycle after the pulse.
- Incoming request: on arp_rx_done with arp_rx_type=0, set reply_pend and latch the peer MAC and IP into reply registers. A second request before service overwrites the latch; only the latest peer is answered.
- IDLE priority: reply_pend first, then resolve_req.
  - reply_pend → TX_REPLY.
  - resolve_req with cache_valid and cache_ip==resolve_ip → resolve_done pulse next cycle; no frame is sent; stay IDLE.
  - resolve_req otherwise → latch the target IP, clear retry_cnt, go to TX_REQ.
  - resolve_req while busy=1 is ignored. Software polls busy.
- TX_REPLY: arp_tx_en=1 for one cycle, arp_tx_type=1, tx_dest = latched peer. Clear reply_pend, go to WAIT_REPLY_TX.
  - Latency: arp_rx_done at cycle N with controller idle → arp_tx_en at N+2.
- TX_REQ: arp_tx_en=1 for one cycle, arp_tx_type=0, tx_dest_mac=all-ones, tx_dest_ip=target. Go to WAIT_REQ_TX.
- WAIT_REPLY_TX / WAIT_REQ_TX: hold tx_dest and arp_tx_type stable until arp_tx_done. Then:
  - WAIT_REQ_TX → WAIT_RESP, timer cleared.
  - WAIT_REPLY_TX → WAIT_RESP if a resolve is outstanding (resume flag), else IDLE.
- WAIT_RESP: timer increments each cycle.
  - arp_rx_done with rx_source_ip==target (request or reply): resolve_done pulse the next cycle (cache already updated that edge), retry_cnt cleared, go to IDLE.
  - reply_pend set: set resume flag, freeze timer, go to TX_REPLY. Afterwards return to WAIT_RESP with the timer value kept.
  - timer == TIMEOUT_CYCLES-1: if retry_cnt < MAX_RETRY, increment retry_cnt and go to TX_REQ; else pulse resolve_fail and go to IDLE. Cache is unchanged on failure.
  - Match and timeout in the same cycle: match wins.
- Simultaneous arp_rx_done (request) and resolve_req in IDLE: the reply is serviced first and the resolve_req is dropped.
- arp_tx_done never arrives: the controller stays in the WAIT_*_TX state. There is no watchdog; reset recovers.
- Reset mid-operation: immediate return to IDLE, all pulses deasserted, cache invalidated.

Test Plan:
- Request in: arp_rx_done, type=0, mac=00_11_22_33_44_55, ip=c0a8_0102 → arp_tx_en at N+2, type=1, tx_dest echoes that pair. cache_valid=1 and cache_ip=c0a8_0102 at N+1. busy falls after arp_tx_done.
- Cache hit: after the previous case, resolve_req ip=c0a8_0102 → resolve_done next cycle, no arp_tx_en.
- Resolve miss: resolve_req ip=c0a8_0105, TIMEOUT_CYCLES=100 → request frame sent with tx_dest_mac=ffff_ffff_ffff. Reply type=1 from ip c0a8_0105 at cycle 40 of WAIT_RESP → resolve_done, cache_mac updated.
- Timeout/fail: no reply, MAX_RETRY=3 → exactly 4 arp_tx_en with type=0, each 100 cycles after the prior arp_tx_done. Then one resolve_fail pulse and busy=0.
- Interleave: ARP request arrives at WAIT_RESP cycle 50 → reply frame sent, timer held at 50. Timeout occurs 50 cycles after resume.
- Async reset asserted in WAIT_REQ_TX → all outputs 0 immediately, state IDLE. A resolve_req after release is accepted.
